// File: rtl/md_unit.sv
// md_unit: iterative multiply/divide unit owning the HI/LO register pair.
// Optional build macro MD_EARLY_OUT_EN lets multiplies leave CALC once the remaining multiplier bits are zero.
module md_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_wr,
    input  logic             lo_wr,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} state_t;
    state_t state_reg, state_next;

    logic               is_div_reg, neg_res_reg, neg_rem_reg;
    logic               done_reg, dbz_reg;
    logic [CW-1:0]      cnt_reg;
    logic [2*WIDTH-1:0] acc_reg, mcand_reg;
    logic [WIDTH-1:0]   mplier_reg, divisor_reg, rem_reg, a_orig_reg;
    logic [WIDTH-1:0]   hi_reg, lo_reg;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               cnt_last, mul_last, calc_last;
    logic [WIDTH:0]     partial, diff;
    logic               fits;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    // Signed ops work on magnitudes; signs are reapplied in FIX.
    assign a_neg = ~op[0] & a[WIDTH-1];
    assign b_neg = ~op[0] & b[WIDTH-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    assign cnt_last = (cnt_reg == CW'(WIDTH - 1));
`ifdef MD_EARLY_OUT_EN
    assign mul_last = cnt_last | (mplier_reg[WIDTH-1:1] == '0);
`else
    assign mul_last = cnt_last;
`endif
    assign calc_last = is_div_reg ? cnt_last : mul_last;

    // Remainder stays below the divisor, so the top diff bit is exactly the borrow.
    assign partial = {rem_reg, mplier_reg[WIDTH-1]};
    assign diff    = partial - {1'b0, divisor_reg};
    assign fits    = ~diff[WIDTH];

    assign prod_fix = neg_res_reg ? -acc_reg : acc_reg;
    assign quo_fix  = neg_res_reg ? -mplier_reg : mplier_reg;
    assign rem_fix  = neg_rem_reg ? -rem_reg : rem_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (calc_last) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_reg != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_div_reg  <= 1'b0;
            neg_res_reg <= 1'b0;
            neg_rem_reg <= 1'b0;
            done_reg    <= 1'b0;
            dbz_reg     <= 1'b0;
            cnt_reg     <= '0;
            acc_reg     <= '0;
            mcand_reg   <= '0;
            mplier_reg  <= '0;
            divisor_reg <= '0;
            rem_reg     <= '0;
            a_orig_reg  <= '0;
            hi_reg      <= '0;
            lo_reg      <= '0;
        end else begin
            done_reg <= (state_reg == FIX);
            case (state_reg)
                IDLE: begin
                    if (hi_wr) hi_reg <= wr_data;
                    if (lo_wr) lo_reg <= wr_data;
                    if (start) begin
                        is_div_reg  <= op[1];
                        neg_res_reg <= a_neg ^ b_neg;
                        neg_rem_reg <= a_neg;
                        dbz_reg     <= op[1] & (b == '0);
                        cnt_reg     <= '0;
                        acc_reg     <= '0;
                        rem_reg     <= '0;
                        mcand_reg   <= {{WIDTH{1'b0}}, a_mag};
                        mplier_reg  <= op[1] ? a_mag : b_mag;
                        divisor_reg <= b_mag;
                        a_orig_reg  <= a;
                    end
                end
                CALC: begin
                    cnt_reg <= cnt_reg + CW'(1);
                    if (is_div_reg) begin
                        // Dividend shifts out of the top, quotient bits shift in at the bottom.
                        rem_reg    <= fits ? diff[WIDTH-1:0] : partial[WIDTH-1:0];
                        mplier_reg <= {mplier_reg[WIDTH-2:0], fits};
                    end else begin
                        if (mplier_reg[0]) acc_reg <= acc_reg + mcand_reg;
                        mcand_reg  <= mcand_reg << 1;
                        mplier_reg <= mplier_reg >> 1;
                    end
                end
                FIX: begin
                    if (!is_div_reg) begin
                        {hi_reg, lo_reg} <= prod_fix;
                    end else if (dbz_reg) begin
                        hi_reg <= a_orig_reg;
                        lo_reg <= '1;
                    end else begin
                        hi_reg <= rem_fix;
                        lo_reg <= quo_fix;
                    end
                end
                default: ;
            endcase
        end
    end

    assign done        = done_reg;
    assign div_by_zero = dbz_reg;
    assign hi          = hi_reg;
    assign lo          = lo_reg;
endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: arithmetic reference model plus per-cycle compare and directed literal cases.
`timescale 1ns/1ps
module tb_md_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        hi_wr, lo_wr;
    logic [31:0] wr_data;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    md_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .hi_wr(hi_wr), .lo_wr(lo_wr), .wr_data(wr_data),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference results straight from the arithmetic definitions.
    function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx, sy, q, r;
        logic [63:0] res;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        res = '0;
        case (o)
            2'b00: res = 64'(sx * sy);
            2'b01: res = {32'h0, x} * {32'h0, y};
            2'b10: begin
                if (y == 0) res = {x, 32'hFFFF_FFFF};
                else begin
                    q = sx / sy;
                    r = sx % sy;
                    res = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (y == 0) res = {x, 32'hFFFF_FFFF};
                else res = {x % y, x / y};
            end
        endcase
        return res;
    endfunction

    function automatic int ref_latency(input logic [1:0] o, input logic [31:0] y);
        int calc;
        calc = 32;
`ifdef MD_EARLY_OUT_EN
        if (!o[1]) begin
            logic [31:0] m;
            m = (!o[0] && y[31]) ? -y : y;
            calc = 1;
            for (int i = 0; i < 32; i++) if (m[i]) calc = i + 1;
        end
`else
        if (o[1]) calc = 32;
`endif
        return calc + 2;
    endfunction

    // Transaction-level model: remaining-cycle countdown, result loaded when it expires.
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    logic        m_done, m_dbz;
    int          m_rem;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hi <= '0; m_lo <= '0; p_hi <= '0; p_lo <= '0;
            m_done <= 1'b0; m_dbz <= 1'b0; m_rem <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_rem != 0) begin
                m_rem <= m_rem - 1;
                if (m_rem == 1) begin
                    m_hi <= p_hi;
                    m_lo <= p_lo;
                    m_done <= 1'b1;
                end
            end else begin
                if (hi_wr) m_hi <= wr_data;
                if (lo_wr) m_lo <= wr_data;
                if (start) begin
                    {p_hi, p_lo} <= ref_result(op, a, b);
                    m_dbz <= op[1] && (b == 32'h0);
                    m_rem <= ref_latency(op, b) - 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("busy", 64'(busy), 64'(m_rem != 0));
        check("done", 64'(done), 64'(m_done));
        check("div_by_zero", 64'(div_by_zero), 64'(m_dbz));
        check("hi", 64'(hi), 64'(m_hi));
        check("lo", 64'(lo), 64'(m_lo));
    end

    // Caller is mid-cycle 0; returns at cycle 1 + 1ns.
    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic hw, input logic lw, input logic [31:0] wd);
        start = 1'b1; op = o; a = x; b = y; hi_wr = hw; lo_wr = lw; wr_data = wd;
        @(posedge clk); #1;
        start = 1'b0; hi_wr = 1'b0; lo_wr = 1'b0;
    endtask

    // Returns at the negedge of the done cycle with its cycle number.
    task automatic wait_done(input int c0, output int cyc);
        cyc = c0;
        while (cyc < 200) begin
            @(negedge clk);
            if (done === 1'b1) break;
            cyc++;
        end
        if (done !== 1'b1) check("done_timeout", 64'(done), 64'(1));
    endtask

    task automatic run(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, output int cyc);
        @(posedge clk); #1;
        issue(o, x, y, 1'b0, 1'b0, 32'h0);
        wait_done(1, cyc);
        $display("op=%0d a=%h b=%h -> hi=%h lo=%h dbz=%0d cycles=%0d", o, x, y, hi, lo, div_by_zero, cyc);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [31:0] specials [6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h5};

    initial begin
        int          cyc, c0, gap, lat_exp;
        logic [1:0]  o;
        logic [31:0] x, y;

        rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
        hi_wr = 1'b0; lo_wr = 1'b0; wr_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_hi", 64'(hi), 64'(0));
        rst_n = 1'b1;

        run(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc);
        check("multu_max_hi", 64'(hi), 64'(32'hFFFF_FFFE));
        check("multu_max_lo", 64'(lo), 64'(32'h0000_0001));
        check("multu_max_latency", 64'(cyc), 64'(34));

        run(2'b00, 32'hFFFF_FFFD, 32'h7, cyc);
        check("mult_neg_hi", 64'(hi), 64'(32'hFFFF_FFFF));
        check("mult_neg_lo", 64'(lo), 64'(32'hFFFF_FFEB));

        run(2'b10, 32'hFFFF_FFF9, 32'h2, cyc);
        check("div_neg_lo", 64'(lo), 64'(32'hFFFF_FFFD));
        check("div_neg_hi", 64'(hi), 64'(32'hFFFF_FFFF));
        check("div_latency", 64'(cyc), 64'(34));

        run(2'b11, 32'h7, 32'h0, cyc);
        check("divu_zero_lo", 64'(lo), 64'(32'hFFFF_FFFF));
        check("divu_zero_hi", 64'(hi), 64'(32'h7));
        check("divu_zero_flag", 64'(div_by_zero), 64'(1));

        run(2'b11, 32'd100, 32'd7, cyc);
        check("divu_lo", 64'(lo), 64'(32'd14));
        check("divu_hi", 64'(hi), 64'(32'd2));
        check("divu_flag_clear", 64'(div_by_zero), 64'(0));

        run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
        check("div_ovf_lo", 64'(lo), 64'(32'h8000_0000));
        check("div_ovf_hi", 64'(hi), 64'(32'h0));

        // start and mthi pulsed mid-operation must both be dropped
        @(posedge clk); #1;
        issue(2'b00, 32'h2, 32'h7FFF_FFFF, 1'b0, 1'b0, 32'h0);
        repeat (4) begin @(posedge clk); #1; end
        start = 1'b1; op = 2'b11; a = 32'd9; b = 32'd3; hi_wr = 1'b1; wr_data = 32'h1234;
        @(posedge clk); #1;
        start = 1'b0; hi_wr = 1'b0;
        wait_done(6, cyc);
        $display("op=0 a=00000002 b=7fffffff -> hi=%h lo=%h cycles=%0d", hi, lo, cyc);
        check("ignored_hi", 64'(hi), 64'(32'h0));
        check("ignored_lo", 64'(lo), 64'(32'hFFFF_FFFE));

        @(posedge clk); #1;
        hi_wr = 1'b1; wr_data = 32'h1234;
        @(posedge clk); #1;
        hi_wr = 1'b0;
        check("mthi_hi", 64'(hi), 64'(32'h1234));
        check("mthi_lo_kept", 64'(lo), 64'(32'hFFFF_FFFE));

        // Reset in cycle 10 of a div with a zero divisor (flag set while busy)
        @(posedge clk); #1;
        issue(2'b10, 32'd5, 32'd0, 1'b0, 1'b0, 32'h0);
        repeat (9) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_hi", 64'(hi), 64'(0));
        check("rst_lo", 64'(lo), 64'(0));
        check("rst_dbz", 64'(div_by_zero), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;

        run(2'b01, 32'd6, 32'd7, cyc);
        check("post_rst_lo", 64'(lo), 64'(32'd42));
        check("post_rst_hi", 64'(hi), 64'(32'd0));
`ifdef MD_EARLY_OUT_EN
        check("post_rst_latency", 64'(cyc), 64'(5));
`else
        check("post_rst_latency", 64'(cyc), 64'(34));
`endif

        run(2'b01, 32'd5, 32'd3, cyc);
        check("multu_small_lo", 64'(lo), 64'(32'd15));
`ifdef MD_EARLY_OUT_EN
        check("multu_small_latency", 64'(cyc), 64'(4));
`else
        check("multu_small_latency", 64'(cyc), 64'(34));
`endif

        for (int n = 0; n < 150; n++) begin
            o = 2'($urandom_range(0, 3));
            x = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
            y = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
            if ($urandom_range(0, 2) == 0) y = 32'($urandom_range(0, 20));
            if ($urandom_range(0, 1) == 1) begin
                #1;
            end else begin
                @(posedge clk); #1;
                gap = $urandom_range(0, 2);
                for (int g = 0; g < gap; g++) begin
                    hi_wr = 1'($urandom_range(0, 1));
                    lo_wr = 1'($urandom_range(0, 1));
                    wr_data = $urandom;
                    @(posedge clk); #1;
                    hi_wr = 1'b0; lo_wr = 1'b0;
                end
            end
            issue(o, x, y, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), $urandom);
            c0 = 1;
            if ($urandom_range(0, 2) == 0) begin
                @(posedge clk); #1;
                start = 1'b1; op = 2'($urandom_range(0, 3)); a = $urandom; b = $urandom;
                hi_wr = 1'($urandom_range(0, 1)); lo_wr = 1'($urandom_range(0, 1)); wr_data = $urandom;
                @(posedge clk); #1;
                start = 1'b0; hi_wr = 1'b0; lo_wr = 1'b0;
                c0 = 3;
            end
            wait_done(c0, cyc);
            lat_exp = ref_latency(o, y);
            check("rand_latency", 64'(cyc), 64'(lat_exp));
            $display("op=%0d a=%h b=%h -> hi=%h lo=%h dbz=%0d cycles=%0d", o, x, y, hi, lo, div_by_zero, cyc);
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/md_unit.md
# md_unit

Parametrised iterative multiply/divide unit owning the HI/LO register pair of the multicycle MIPS core. It executes mult, multu, div and divu over a start/busy/done handshake with the control FSM. It services mthi/mtlo writes and drives HI/LO for mfhi/mflo. It sits beside the ALU and takes operands from the registered rs/rt read data.

## Interface
- WIDTH, 32: operand width; HI and LO are each WIDTH bits. Must be ≥ 2.
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request a new operation; accepted only when busy=0
- op  in  2  operation: 00 mult, 01 multu, 10 div, 11 divu; sampled with start
- a  in  WIDTH  rs operand (multiplicand / dividend); sampled with start
- b  in  WIDTH  rt operand (multiplier / divisor); sampled with start
- hi_wr  in  1  mthi: load wr_data into HI
- lo_wr  in  1  mtlo: load wr_data into LO
- wr_data  in  WIDTH  data for hi_wr/lo_wr
- busy  out  1  operation in progress; reset 0
- done  out  1  one-cycle pulse, HI/LO hold the new result; reset 0
- div_by_zero  out  1  last accepted div/divu had b=0; reset 0
- hi  out  WIDTH  HI register; reset 0
- lo  out  WIDTH  LO register; reset 0

## Operation
- FSM states: IDLE, CALC, FIX. Reset state IDLE. busy = (state != IDLE).
- IDLE: start=1 latches op, |a| and |b| (magnitudes for signed ops, raw values for unsigned) and the result signs, clears the iteration counter, sets div_by_zero = (op[1] & b==0), and moves to CALC.
- CALC, multiply: radix-2 shift-add, one multiplier bit per cycle into a 2·WIDTH-bit accumulator.
- CALC, divide: restoring division, one quotient bit per cycle, WIDTH-bit remainder, WIDTH+1-bit trial subtract.
- CALC lasts WIDTH cycles, then the FSM moves to FIX.
- FIX: apply sign correction, load HI/LO, set done for the next cycle, and go to IDLE.
- mult/multu: {HI,LO} = full 2·WIDTH-bit product. Signed product is negated when the operand signs differ.
- div/divu: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
- Signed div of −2^(WIDTH−1) by −1: LO = 0x80000000, HI = 0 for WIDTH=32. No exception is raised.
- Divide by zero: LO = all ones, HI = a (the original dividend, not its magnitude). div_by_zero stays set until the next accepted start.
- start while busy=1 is ignored. The request is not queued.
- hi_wr/lo_wr:
  - While busy=0, they update HI/LO on the next edge.
  - While busy=1, they are ignored.
  - If start and hi_wr/lo_wr are both asserted in IDLE, the register write takes effect and the operation still starts.
  - The operation result later overwrites the written value.
- HI/LO change only at FIX, on hi_wr/lo_wr, or on reset.
- Reset assertion at any time, including mid-CALC, forces state IDLE and all outputs and internal registers to 0 immediately. The in-flight operation is discarded.

## Timing
- Cycle 0: start=1 with busy=0.
- Cycles 1..WIDTH: CALC.
- Cycle WIDTH+1: FIX.
- Cycle WIDTH+2: done=1, busy=0, new HI/LO visible.
- Latency from start to done is WIDTH+2 cycles; it is 34 for WIDTH=32.
- busy is high from cycle 1 through cycle WIDTH+1.
- A new start is accepted in the done cycle, which gives back-to-back operations with no bubble.
- done is never asserted except in the single cycle after FIX.
- hi_wr/lo_wr have 1-cycle latency: the value is visible the cycle after the write is asserted.

## Configuration
- MD_EARLY_OUT_EN defined:
  - mult/multu leave CALC as soon as the remaining unshifted multiplier bits are all zero, with a minimum of 1 CALC cycle.
  - CALC length becomes max(1, index of the MSB of |b| + 1).
  - For b=0, CALC lasts 1 cycle.
  - Divide latency is unchanged.
  - Results are bit-identical to the non-early-out build.
- MD_EARLY_OUT_EN undefined: every operation takes exactly WIDTH CALC cycles. No early-out logic is synthesised.

## Test plan
- multu a=0xFFFFFFFF, b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001, done in cycle 34, busy high in cycles 1–33.
- mult a=0xFFFFFFFD (−3), b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB; then div a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- divu a=7, b=0 → lo=0xFFFFFFFF, hi=7, div_by_zero=1; then divu 100/7 → lo=14, hi=2, div_by_zero=0.
- In cycle 5 of a mult, pulse start (divu 9/3) and hi_wr with wr_data 0x1234 → both ignored, mult result stands. In IDLE, hi_wr with 0x1234 → hi=0x1234 the next cycle, lo unchanged.
- Assert rst_n=0 in cycle 10 of a div → busy, done, hi, lo and div_by_zero are 0 immediately. After release, a multu 6×7 gives lo=42, hi=0 in 34 cycles.
- With MD_EARLY_OUT_EN, multu 5×3 → lo=15, done in cycle 4. div latency is still 34. Without the macro, the same multu takes 34 cycles.
